// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divider.
package div_pkg;

  // One restoring iteration produces one quotient bit, so a 32-bit divide takes 32 steps.
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift {rem, quo} left by one and
// subtract the divisor when it fits, setting the new quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // The shifted value is always below 2*divisor (or below 2^WIDTH when the
  // divisor is zero), so a clear borrow bit means the subtraction fits.
  assign w_fits = ~w_diff[WIDTH];

  always_comb begin
    o_rem = w_shifted[WIDTH-1:0];
    o_quo = {i_quo[WIDTH-2:0], 1'b0};
    if (w_fits) begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_div.sv
// Iterative DIV/DIVU unit for the execute stage; result = {remainder, quotient}
// goes straight into HI/LO when valid pulses.
module hilo_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 annul,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_nextState;

  logic                 r_signQ;
  logic                 r_signR;
  logic [WIDTH-1:0]     r_divisor;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_lastIter;
  logic [WIDTH-1:0]     w_aMag;
  logic [WIDTH-1:0]     w_bMag;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [WIDTH-1:0]     w_quoFinal;
  logic [WIDTH-1:0]     w_remFinal;

  assign w_accept   = (r_state == IDLE) && start && !annul;
  assign w_lastIter = (r_cnt == LAST_CNT);

  // Negation wraps modulo 2^WIDTH, so the most negative value keeps its bit pattern.
  assign w_aMag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_bMag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_remNext),
    .o_quo     (w_quoNext)
  );

  assign w_quoFinal = r_signQ ? (~w_quoNext + 1'b1) : w_quoNext;
  assign w_remFinal = r_signR ? (~w_remNext + 1'b1) : w_remNext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    valid       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = DIV;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (w_lastIter) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        valid       = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (annul) begin
      w_nextState = IDLE;
    end
  end

  // An annulled final iteration must not disturb the previously written result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_signQ   <= 1'b0;
      r_signR   <= 1'b0;
      r_divisor <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_signQ   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_signR   <= is_signed & a[WIDTH-1];
      r_divisor <= w_bMag;
      r_rem     <= '0;
      r_quo     <= w_aMag;
      r_cnt     <= '0;
    end else if ((r_state == DIV) && !annul) begin
      r_rem <= w_remNext;
      r_quo <= w_quoNext;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_lastIter) begin
        r_result <= {w_remFinal, w_quoFinal};
      end
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_hilo_div.sv
// Scoreboard bench for hilo_div: stimulus pushes expected {rem, quo} and the
// valid cycle; an independent monitor pops and compares on every valid.
module tb_hilo_div;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          annul;
  logic          busy;
  logic          valid;
  logic [2*W-1:0] result;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  int          tests = 0;
  int          fails = 0;
  int          cycCount = 0;
  logic [63:0] lastResult = '0;
  logic        prevValid = 1'b0;

  hilo_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .annul     (annul),
    .busy      (busy),
    .valid     (valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  // Reference: truncating division on magnitudes, then sign fix-up; x/0 gives all-ones, rem |x|.
  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    longint unsigned mx, my, q, r;
    logic nq, nr;
    logic [31:0] q32, r32;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    mx = (sx < 0) ? longint'(-sx) : sx;
    my = (sy < 0) ? longint'(-sy) : sy;
    nq = s && ((sx < 0) != (sy < 0));
    nr = s && (sx < 0);
    if (my == 0) begin
      q = 64'hFFFF_FFFF;
      r = mx;
    end else begin
      q = mx / my;
      r = mx % my;
    end
    q32 = q[31:0];
    r32 = r[31:0];
    if (nq) q32 = -q32;
    if (nr) r32 = -r32;
    return {r32, q32};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cycCount);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid) begin
      checkOutput("validPulse", {63'b0, prevValid}, 64'd0);
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedValid: got result %h, expected no valid (cycle %0d)", result, cycCount);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("validCycle", 64'(cycCount), 64'(e.cyc));
        lastResult = e.res;
      end
    end
    prevValid = valid;
  end

  // Called at a negedge; the following posedge samples start.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic isS);
    exp_t e;
    a         = ia;
    b         = ib;
    is_signed = isS;
    start     = 1'b1;
    e.res     = refDiv(ia, ib, isS);
    e.cyc     = cycCount + 1 + 32;
    sbQ.push_back(e);
  endtask

  task automatic runOp(input logic [31:0] ia, input logic [31:0] ib, input logic isS);
    int busyCycles;
    applyStimulus(ia, ib, isS);
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput("busyLength", 64'(busyCycles), 64'd33);
    checkOutput("resultHold", result, refDiv(ia, ib, isS));
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, got cycle %0d, expected < 100000", cycCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [31:0] ra, rb;
    logic        rs;
    exp_t        e;
    int          c;

    rst = 1'b0; start = 1'b0; annul = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",   {63'b0, busy},  64'd0);
    checkOutput("rstValid",  {63'b0, valid}, 64'd0);
    checkOutput("rstResult", result,         64'd0);
    rst = 1'b1;
    @(negedge clk);

    runOp(32'd100,        32'd7,        1'b0);
    runOp(32'hFFFF_FFF9,  32'd2,        1'b1);
    runOp(32'h8000_0000,  32'hFFFF_FFFF, 1'b1);
    runOp(32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    runOp(32'h0000_1234,  32'd0,        1'b0);
    runOp(32'hFFFF_FFFB,  32'd0,        1'b1);

    for (int n = 0; n < 30; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'd1;
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        4: rb = $urandom_range(1, 255);
        default: ;
      endcase
      runOp(ra, rb, rs);
    end

    // Annul mid-operation, then restart immediately.
    applyStimulus($urandom, $urandom_range(1, 1000), 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    void'(sbQ.pop_back());
    checkOutput("annulBusy",   {63'b0, busy},  64'd0);
    checkOutput("annulValid",  {63'b0, valid}, 64'd0);
    checkOutput("annulResult", result,         lastResult);
    annul = 1'b0;
    runOp(32'd1000, 32'd33, 1'b0);

    // Start and annul together in IDLE are not accepted.
    start = 1'b1; annul = 1'b1; a = $urandom; b = $urandom; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    checkOutput("startAnnulBusy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    checkOutput("startAnnulBusy2", {63'b0, busy}, 64'd0);

    // Start held high: accepts at 34-cycle spacing.
    ra = $urandom; rb = $urandom_range(1, 65535);
    c = cycCount;
    applyStimulus(ra, rb, 1'b1);
    e.res = refDiv(ra, rb, 1'b1);
    e.cyc = c + 67;
    sbQ.push_back(e);
    e.cyc = c + 101;
    sbQ.push_back(e);
    repeat (69) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checkOutput("contPending", 64'(sbQ.size()), 64'd0);

    // Reset mid-operation behaves as annul and clears result.
    applyStimulus($urandom, $urandom_range(1, 1000), 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    void'(sbQ.pop_back());
    checkOutput("midRstBusy",   {63'b0, busy},  64'd0);
    checkOutput("midRstValid",  {63'b0, valid}, 64'd0);
    checkOutput("midRstResult", result,         64'd0);
    lastResult = '0;
    rst = 1'b1;
    @(negedge clk);
    runOp(32'hFFFF_FF9C, 32'd7, 1'b1);

    for (int i = 0; i < 200 && sbQ.size() > 0; i++) @(negedge clk);
    checkOutput("pendingEmpty", 64'(sbQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
